// File: rtl/nrf24_radio_engine.sv
// rtl/nrf24_radio_engine.sv - nRF24L01+ static-payload radio sequencer over SPI
// Purpose: writes CONFIG after reset or a mode change, uploads and launches TX
//          payloads, services RX interrupts, clears STATUS and reports outcomes.
// Ports:
//   clk, reset_n                  clock, synchronous active-low reset
//   mode_rx                       1 = primary receiver, 0 = primary transmitter
//   tx_payload, tx_valid, tx_ready  payload handshake, byte 0 (bits 7:0) sent first
//   rx_payload, rx_valid          received payload and its 1-cycle strobe
//   tx_done, tx_fail, tx_timeout  1-cycle TX outcome strobes
//   ce, csn, sck, mosi            radio control and SPI outputs (mode 0, MSB first)
//   miso, irq                     SPI input and active-low radio interrupt
module nrf24_radio_engine #(
   parameter int PAYLOAD_BYTES = 4,
   parameter int SCK_DIV       = 4,
   parameter int CE_PULSE      = 16,
   parameter int TX_TIMEOUT    = 65535
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       mode_rx,
   input  logic [8*PAYLOAD_BYTES-1:0] tx_payload,
   input  logic                       tx_valid,
   output logic                       tx_ready,
   output logic [8*PAYLOAD_BYTES-1:0] rx_payload,
   output logic                       rx_valid,
   output logic                       tx_done,
   output logic                       tx_fail,
   output logic                       tx_timeout,
   output logic                       ce,
   output logic                       csn,
   output logic                       sck,
   output logic                       mosi,
   input  logic                       miso,
   input  logic                       irq
);
   localparam int PW   = 8*PAYLOAD_BYTES;
   localparam int IW   = $clog2(PAYLOAD_BYTES+2);
   localparam int DW   = $clog2(2*SCK_DIV);
   localparam int TMAX = (TX_TIMEOUT > CE_PULSE) ? TX_TIMEOUT : CE_PULSE;
   localparam int TW   = $clog2(TMAX+1);

   typedef enum logic [2:0] {
      S_BOOT, S_IDLE, S_TX_LOAD, S_TX_PULSE, S_TX_WAIT, S_STAT_CLR, S_FLUSH, S_RX_READ
   } state_t;

   typedef enum logic [2:0] {
      X_IDLE, X_SETUP, X_HIGH, X_LOW, X_HOLD, X_GAP, X_DONE
   } xphase_t;

   state_t          state, state_nxt;
   xphase_t         xphase;
   logic [DW-1:0]   div_cnt;
   logic [2:0]      bit_cnt;
   logic [IW-1:0]   byte_idx;
   logic [IW-1:0]   last_idx;
   logic [7:0]      tx_sh, rx_sh;
   logic [7:0]      cur_byte, nxt_byte;
   logic [PW-1:0]   payload_q, rx_buf;
   logic [TW-1:0]   tmr;
   logic            mode_q;
   // Only TX_DS (5) and MAX_RT (4) steer the FSM; RX_DR always returns to IDLE.
   logic [5:4]      status;
   logic            xfer_req, xfer_done;

   assign xfer_done = (xphase == X_DONE);

   // Byte k of the transaction owned by state st.
   function automatic logic [7:0] byte_at(input state_t st, input logic [IW-1:0] idx,
                                          input logic [PW-1:0] pl, input logic md);
      logic [7:0] b;
      b = 8'h00;
      case (st)
         S_BOOT:     b = (idx == '0) ? 8'h20 : {7'b0000111, md};
         S_TX_LOAD: begin
            b = 8'hA0;
            for (int k = 0; k < PAYLOAD_BYTES; k++)
               if (idx == IW'(k+1)) b = pl[8*k +: 8];
         end
         S_STAT_CLR: b = (idx == '0) ? 8'h27 : 8'h70;
         S_FLUSH:    b = 8'hE1;
         S_RX_READ:  b = (idx == '0) ? 8'h61 : 8'hFF;
         default:    b = 8'h00;
      endcase
      return b;
   endfunction

   // FSM: state register
   always_ff @(posedge clk) begin
      if (!reset_n) state <= S_BOOT;
      else          state <= state_nxt;
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      case (state)
         S_BOOT:     if (xfer_done) state_nxt = S_IDLE;
         S_IDLE: begin
            if (mode_rx != mode_q)  state_nxt = S_BOOT;
            else if (!mode_q) begin
               if (tx_valid)        state_nxt = S_TX_LOAD;
            end
            else if (!irq)          state_nxt = S_RX_READ;
         end
         S_TX_LOAD:  if (xfer_done) state_nxt = S_TX_PULSE;
         S_TX_PULSE: if (tmr == TW'(CE_PULSE-1)) state_nxt = S_TX_WAIT;
         S_TX_WAIT: begin
            if (!irq)                              state_nxt = S_STAT_CLR;
            else if (tmr == TW'(TX_TIMEOUT-1))     state_nxt = S_FLUSH;
         end
         S_STAT_CLR: if (xfer_done) begin
            if (!mode_q && !status[5] && status[4]) state_nxt = S_FLUSH;
            else                                    state_nxt = S_IDLE;
         end
         S_FLUSH:    if (xfer_done) state_nxt = S_IDLE;
         S_RX_READ:  if (xfer_done) state_nxt = S_STAT_CLR;
         default:    state_nxt = S_BOOT;
      endcase
   end

   // FSM: outputs and SPI byte selection
   always_comb begin
      ce       = 1'b0;
      tx_ready = 1'b0;
      xfer_req = 1'b0;
      last_idx = '0;
      case (state)
         S_BOOT:     begin xfer_req = 1'b1; last_idx = IW'(1); end
         S_IDLE: begin
            tx_ready = !mode_rx && !mode_q;
            ce       = mode_rx && mode_q;
         end
         S_TX_LOAD:  begin xfer_req = 1'b1; last_idx = IW'(PAYLOAD_BYTES); end
         S_TX_PULSE: ce = 1'b1;
         S_STAT_CLR: begin xfer_req = 1'b1; last_idx = IW'(1); end
         S_FLUSH:    xfer_req = 1'b1;
         S_RX_READ:  begin xfer_req = 1'b1; last_idx = IW'(PAYLOAD_BYTES); end
         default:    ;
      endcase
      cur_byte = byte_at(state, byte_idx, payload_q, mode_q);
      nxt_byte = byte_at(state, byte_idx + 1'b1, payload_q, mode_q);
   end

   // Control registers, dwell timer and outcome strobes
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         mode_q     <= 1'b0;
         payload_q  <= '0;
         tmr        <= '0;
         tx_done    <= 1'b0;
         tx_fail    <= 1'b0;
         tx_timeout <= 1'b0;
      end else begin
         if (state == S_BOOT && xphase == X_IDLE) mode_q <= mode_rx;
         if (state == S_IDLE && tx_ready && tx_valid) payload_q <= tx_payload;
         // Timer restarts on every state change and saturates.
         if (state_nxt != state)  tmr <= '0;
         else if (tmr != TW'(TMAX)) tmr <= tmr + 1'b1;
         tx_done    <= (state == S_STAT_CLR) && xfer_done && !mode_q && status[5];
         tx_fail    <= (state == S_STAT_CLR) && xfer_done && !mode_q && !status[5] && status[4];
         tx_timeout <= (state == S_TX_WAIT) && irq && (tmr == TW'(TX_TIMEOUT-1));
      end
   end

   // SPI engine: setup, 8 bits per byte, hold, then inter-transaction gap
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         xphase     <= X_IDLE;
         csn        <= 1'b1;
         sck        <= 1'b0;
         mosi       <= 1'b0;
         div_cnt    <= '0;
         bit_cnt    <= '0;
         byte_idx   <= '0;
         tx_sh      <= '0;
         rx_sh      <= '0;
         status     <= '0;
         rx_buf     <= '0;
         rx_payload <= '0;
         rx_valid   <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         case (xphase)
            X_IDLE: if (xfer_req) begin
               csn      <= 1'b0;
               tx_sh    <= cur_byte;
               mosi     <= cur_byte[7];
               div_cnt  <= '0;
               bit_cnt  <= '0;
               xphase   <= X_SETUP;
            end
            X_SETUP, X_LOW: begin
               if (div_cnt == DW'(SCK_DIV-1)) begin
                  div_cnt <= '0;
                  sck     <= 1'b1;
                  rx_sh   <= {rx_sh[6:0], miso};
                  xphase  <= X_HIGH;
               end else div_cnt <= div_cnt + 1'b1;
            end
            X_HIGH: begin
               if (div_cnt == DW'(SCK_DIV-1)) begin
                  div_cnt <= '0;
                  sck     <= 1'b0;
                  if (bit_cnt == 3'd7) begin
                     bit_cnt <= '0;
                     if (byte_idx == '0) status <= rx_sh[5:4];
                     for (int k = 0; k < PAYLOAD_BYTES; k++)
                        if (byte_idx == IW'(k+1)) rx_buf[8*k +: 8] <= rx_sh;
                     if (byte_idx == last_idx) begin
                        mosi   <= 1'b0;
                        xphase <= X_HOLD;
                     end else begin
                        byte_idx <= byte_idx + 1'b1;
                        tx_sh    <= nxt_byte;
                        mosi     <= nxt_byte[7];
                        xphase   <= X_LOW;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     tx_sh   <= {tx_sh[6:0], 1'b0};
                     mosi    <= tx_sh[6];
                     xphase  <= X_LOW;
                  end
               end else div_cnt <= div_cnt + 1'b1;
            end
            X_HOLD: begin
               if (div_cnt == DW'(SCK_DIV-1)) begin
                  div_cnt  <= '0;
                  csn      <= 1'b1;
                  byte_idx <= '0;
                  // Received payload is published on the csn rising edge.
                  if (state == S_RX_READ) begin
                     rx_payload <= rx_buf;
                     rx_valid   <= 1'b1;
                  end
                  xphase <= X_GAP;
               end else div_cnt <= div_cnt + 1'b1;
            end
            X_GAP: begin
               if (div_cnt == DW'(2*SCK_DIV-1)) begin
                  div_cnt <= '0;
                  xphase  <= X_DONE;
               end else div_cnt <= div_cnt + 1'b1;
            end
            X_DONE:  xphase <= X_IDLE;
            default: xphase <= X_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_nrf24_radio_engine.sv
// tb/tb_nrf24_radio_engine.sv - scoreboard bench for nrf24_radio_engine
module tb_nrf24_radio_engine;
   localparam int PB = 4;
   localparam int SCK_DIV = 4;
   localparam int CE_PULSE = 16;
   localparam int TX_TIMEOUT = 100;

   localparam logic [7:0] K_MOSI = 8'd1;
   localparam logic [7:0] K_DONE = 8'd2;
   localparam logic [7:0] K_FAIL = 8'd3;
   localparam logic [7:0] K_TO   = 8'd4;
   localparam logic [7:0] K_RXV  = 8'd5;

   logic          clk = 1'b0;
   logic          reset_n, mode_rx, tx_valid, miso, irq;
   logic [31:0]   tx_payload;
   logic          tx_ready, rx_valid, tx_done, tx_fail, tx_timeout;
   logic [31:0]   rx_payload;
   logic          ce, csn, sck, mosi;

   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   logic [39:0]   exp_q[$];
   logic [7:0]    model_status = 8'h0E;
   logic [31:0]   model_rx = 32'h0;
   logic          ce_chk_en = 1'b0;

   nrf24_radio_engine #(
      .PAYLOAD_BYTES(PB), .SCK_DIV(SCK_DIV), .CE_PULSE(CE_PULSE), .TX_TIMEOUT(TX_TIMEOUT)
   ) dut (
      .clk(clk), .reset_n(reset_n), .mode_rx(mode_rx),
      .tx_payload(tx_payload), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_payload(rx_payload), .rx_valid(rx_valid),
      .tx_done(tx_done), .tx_fail(tx_fail), .tx_timeout(tx_timeout),
      .ce(ce), .csn(csn), .sck(sck), .mosi(mosi), .miso(miso), .irq(irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [7:0] kind, input logic [31:0] val);
      exp_q.push_back({kind, val});
   endtask

   task automatic score(input logic [7:0] kind, input logic [31:0] val);
      logic [39:0] e;
      if (exp_q.size() == 0) e = {8'hEE, 32'h0};
      else e = exp_q.pop_front();
      check_eq("event", {kind, val}, e);
   endtask

   function automatic logic [7:0] resp_byte(input int k);
      logic [31:0] d;
      d = model_rx;
      if (k == 0) return model_status;
      if (k > PB) return 8'hFF;
      return d[8*(k-1) +: 8];
   endfunction

   // Radio model: SPI slave, event scoreboard, ce and timing monitors.
   logic       csn_p = 1'b1, sck_p = 1'b0, mosi_p = 1'b0, ce_p = 1'b0, first_rise = 1'b0;
   logic [7:0] mosi_sh = 8'h0, miso_sh = 8'h0;
   int         bitn = 0, byten = 0, fall_cyc = 0, ce_run = 0, ce_fall_cyc = 0;

   always @(negedge clk) begin
      if (csn_p && !csn) begin
         bitn = 0; byten = 0; fall_cyc = cyc; first_rise = 1'b1;
         miso_sh = resp_byte(0); miso = miso_sh[7];
      end
      if (!csn && !sck_p && sck) begin
         if (first_rise) begin
            check_eq("csn_to_sck", 64'(cyc - fall_cyc), 64'(SCK_DIV));
            first_rise = 1'b0;
         end
         mosi_sh = {mosi_sh[6:0], mosi};
         bitn++;
         if (bitn == 8) begin
            score(K_MOSI, {24'h0, mosi_sh});
            if (mosi_sh == 8'h70) irq = 1'b1;
            byten++; bitn = 0;
         end
      end
      if (!csn && sck_p && !sck) begin
         if (bitn == 0) miso_sh = resp_byte(byten);
         else miso_sh = {miso_sh[6:0], 1'b0};
         miso = miso_sh[7];
      end
      if (sck && sck_p) check_eq("mosi_hold", mosi, mosi_p);
      if (tx_done) score(K_DONE, 32'h0);
      if (tx_fail) score(K_FAIL, 32'h0);
      if (tx_timeout) begin
         score(K_TO, 32'h0);
         check_eq("timeout_lat", 64'(cyc - ce_fall_cyc), 64'(TX_TIMEOUT));
      end
      if (rx_valid) score(K_RXV, rx_payload);
      if (ce) ce_run++;
      else if (ce_p) begin
         if (ce_chk_en) check_eq("ce_len", 64'(ce_run), 64'(CE_PULSE));
         ce_fall_cyc = cyc; ce_run = 0;
      end
      csn_p = csn; sck_p = sck; mosi_p = mosi; ce_p = ce;
   end

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!tx_ready && n < 5000) begin @(negedge clk); n++; end
      check_eq(tag, tx_ready, 1'b1);
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 5000) begin @(negedge clk); n++; end
      check_eq(tag, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic wait_ce(input string tag, input logic v);
      int n = 0;
      while (ce !== v && n < 5000) begin @(negedge clk); n++; end
      check_eq(tag, ce, v);
   endtask

   task automatic check_reset_outputs();
      check_eq("rst_csn", csn, 1'b1);
      check_eq("rst_sck", sck, 1'b0);
      check_eq("rst_mosi", mosi, 1'b0);
      check_eq("rst_ce", ce, 1'b0);
      check_eq("rst_tx_ready", tx_ready, 1'b0);
      check_eq("rst_strobes", {rx_valid, tx_done, tx_fail, tx_timeout}, 4'b0000);
   endtask

   // outcome: 0 = tx_done, 1 = tx_fail, 2 = timeout
   task automatic do_tx(input logic [31:0] pl, input logic [7:0] st, input int outcome);
      model_status = st;
      push(K_MOSI, 32'hA0);
      for (int k = 0; k < PB; k++) push(K_MOSI, {24'h0, pl[8*k +: 8]});
      if (outcome == 2) begin
         push(K_TO, 32'h0); push(K_MOSI, 32'hE1);
      end else begin
         push(K_MOSI, 32'h27); push(K_MOSI, 32'h70);
         if (outcome == 0) push(K_DONE, 32'h0);
         else begin push(K_FAIL, 32'h0); push(K_MOSI, 32'hE1); end
      end
      tx_payload = pl; tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      if (outcome != 2) begin
         wait_ce("ce_rise", 1'b1);
         wait_ce("ce_fall", 1'b0);
         repeat (20) @(negedge clk);
         irq = 1'b0;
      end
      wait_drain("tx_drain");
      wait_ready("tx_ready_after");
   endtask

   initial begin
      logic [31:0] d;
      reset_n = 1'b0; mode_rx = 1'b0; tx_valid = 1'b0; tx_payload = '0;
      miso = 1'b0; irq = 1'b1;
      repeat (4) @(negedge clk);
      check_reset_outputs();
      check_eq("rst_rx_payload", rx_payload, 32'h0);
      push(K_MOSI, 32'h20); push(K_MOSI, 32'h0E);
      reset_n = 1'b1;
      @(negedge clk);
      check_eq("boot_tx_ready", tx_ready, 1'b0);
      wait_ready("boot_ready");
      wait_drain("boot_drain");
      ce_chk_en = 1'b1;

      do_tx(32'hDEADBEEF, 8'h2E, 0);
      do_tx($urandom, 8'h1E, 1);
      do_tx($urandom, 8'h3E, 0);
      do_tx($urandom, 8'h0E, 2);

      // Receiver mode: mode change re-runs the CONFIG write.
      ce_chk_en = 1'b0;
      mode_rx = 1'b1;
      push(K_MOSI, 32'h20); push(K_MOSI, 32'h0F);
      wait_ce("rx_boot_ce", 1'b1);
      wait_drain("rx_boot_drain");
      check_eq("rx_tx_ready", tx_ready, 1'b0);
      tx_valid = 1'b1;
      for (int r = 0; r < 2; r++) begin
         d = (r == 0) ? 32'h44332211 : $urandom;
         model_rx = d; model_status = 8'h0E;
         push(K_MOSI, 32'h61);
         for (int k = 0; k < PB; k++) push(K_MOSI, 32'hFF);
         push(K_RXV, d); push(K_MOSI, 32'h27); push(K_MOSI, 32'h70);
         irq = 1'b0;
         wait_drain("rx_drain");
         wait_ce("rx_idle_ce", 1'b1);
      end
      tx_valid = 1'b0;
      @(negedge clk);
      mode_rx = 1'b0;
      push(K_MOSI, 32'h20); push(K_MOSI, 32'h0E);
      wait_ready("tx_boot_ready");
      wait_drain("tx_boot_drain");
      ce_chk_en = 1'b1;

      // Reset in the middle of TX_LOAD byte 3.
      d = $urandom;
      push(K_MOSI, 32'hA0);
      for (int k = 0; k < PB; k++) push(K_MOSI, {24'h0, d[8*k +: 8]});
      tx_payload = d; tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      begin
         int n = 0;
         while (exp_q.size() > 2 && n < 5000) begin @(negedge clk); n++; end
         check_eq("mid_load_reached", 64'(exp_q.size()), 64'd2);
      end
      repeat (10) @(negedge clk);
      check_eq("mid_load_csn", csn, 1'b0);
      reset_n = 1'b0;
      @(negedge clk);
      check_reset_outputs();
      exp_q.delete();
      push(K_MOSI, 32'h20); push(K_MOSI, 32'h0E);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      wait_ready("reboot_ready");
      wait_drain("reboot_drain");
      repeat (50) @(negedge clk);
      check_eq("final_queue", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule
